// File: rtl/clken_nco_pkg.sv
// rtl/clken_nco_pkg.sv - shared defaults, legal ranges and lock-qualifier state for clken_nco
package clken_nco_pkg;

    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_LOCK_CYCLES = 1024;

    localparam int MIN_CHANNELS    = 1;
    localparam int MAX_CHANNELS    = 8;
    localparam int MIN_ACC_WIDTH   = 8;
    localparam int MAX_ACC_WIDTH   = 32;
    localparam int MIN_LOCK_CYCLES = 1;
    localparam int MAX_LOCK_CYCLES = 65535;

    // Wide enough for the largest legal LOCK_CYCLES-1
    localparam int LOCK_CNT_W = 16;

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } lock_state_e;

    function automatic int ch_sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/clken_nco_chan.sv
// rtl/clken_nco_chan.sv - one fractional clock-enable channel (num/den accumulator)
module clken_nco_chan
    import clken_nco_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 cfg_load,
    input  logic [ACC_WIDTH-1:0] cfg_num,
    input  logic [ACC_WIDTH-1:0] cfg_den,
    output logic                 clken
);

    logic [ACC_WIDTH-1:0] num_q, num_d;
    logic [ACC_WIDTH-1:0] den_q, den_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 clken_q, clken_d;
    logic [ACC_WIDTH:0]   sum;

    always_comb begin
        num_d   = num_q;
        den_d   = den_q;
        acc_d   = acc_q;
        clken_d = 1'b0;
        // One extra bit so acc+num can never wrap
        sum     = {1'b0, acc_q} + {1'b0, num_q};

        if (cfg_load) begin
            num_d = cfg_num;
            den_d = cfg_den;
            acc_d = '0;
        end else if (!run || num_q == '0 || den_q == '0) begin
            acc_d = '0;
        end else if (num_q >= den_q) begin
            // Saturated ratio: pulse every cycle, keep the phase pinned at zero
            acc_d   = '0;
            clken_d = 1'b1;
        end else if (sum >= {1'b0, den_q}) begin
            acc_d   = ACC_WIDTH'(sum - {1'b0, den_q});
            clken_d = 1'b1;
        end else begin
            acc_d = sum[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q   <= '0;
            den_q   <= ACC_WIDTH'(1);
            acc_q   <= '0;
            clken_q <= 1'b0;
        end else begin
            num_q   <= num_d;
            den_q   <= den_d;
            acc_q   <= acc_d;
            clken_q <= clken_d;
        end
    end

    assign clken = clken_q;

endmodule

// File: rtl/clken_nco.sv
// rtl/clken_nco.sv - multi-channel fractional clock-enable generator gated by PLL lock qualification
module clken_nco
    import clken_nco_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                                clkin,
    input  logic                                reset,
    input  logic                                pll_lock,
    input  logic                                cfg_we,
    input  logic [ch_sel_width(CHANNELS)-1:0]   cfg_ch,
    input  logic [ACC_WIDTH-1:0]                cfg_num,
    input  logic [ACC_WIDTH-1:0]                cfg_den,
    output logic                                ready,
    output logic [CHANNELS-1:0]                 clken
);

    localparam int                  CH_W      = ch_sel_width(CHANNELS);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);

    // Assert immediately, release two clkin edges after reset falls
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int = rst_sync_q[1];

    lock_state_e           state_q, state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  chan_run;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (!pll_lock) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_RUN;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!pll_lock) begin
                    state_d    = ST_WAIT;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_WAIT;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clkin or posedge rst_int) begin
        if (rst_int) begin
            state_q    <= ST_WAIT;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign ready = (state_q == ST_RUN);

    // A lock drop silences the channels on the same edge that leaves RUN
    assign chan_run = ready && pll_lock;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clken_nco_chan #(
            .ACC_WIDTH (ACC_WIDTH)
        ) u_chan (
            .clk      (clkin),
            .rst      (rst_int),
            .run      (chan_run),
            .cfg_load (cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_num  (cfg_num),
            .cfg_den  (cfg_den),
            .clken    (clken[i])
        );
    end

endmodule

// File: tb/tb_clken_nco.sv
// tb/tb_clken_nco.sv - directed self-checking bench for clken_nco with a per-cycle scoreboard
module tb_clken_nco;

    localparam int CH  = 3;
    localparam int AW  = 24;
    localparam int LCK = 16;

    logic          clkin = 1'b0;
    logic          reset;
    logic          pll_lock;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [AW-1:0] cfg_num;
    logic [AW-1:0] cfg_den;
    logic          ready;
    logic [CH-1:0] clken;

    clken_nco #(
        .CHANNELS    (CH),
        .ACC_WIDTH   (AW),
        .LOCK_CYCLES (LCK)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_num  (cfg_num),
        .cfg_den  (cfg_den),
        .ready    (ready),
        .clken    (clken)
    );

    always #5 clkin = ~clkin;

    int tests = 0;
    int fails = 0;

    logic [CH:0] sb_q[$];

    longint m_num[CH];
    longint m_den[CH];
    longint m_k[CH];
    int     m_streak;
    logic   m_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_num[i] = 0;
            m_den[i] = 1;
            m_k[i]   = 0;
        end
        m_streak = 0;
        m_ready  = 1'b0;
    endtask

    // Expected pulse pattern: after k enabled cycles, floor(k*num/den) pulses have occurred
    task automatic step(input logic lk, input logic we, input logic [1:0] ch,
                        input logic [AW-1:0] n, input logic [AW-1:0] d,
                        output logic [CH-1:0] ck, output logic rd);
        logic          en;
        logic [CH-1:0] e_ck;
        logic [CH:0]   exp_v;
        @(negedge clkin);
        pll_lock = lk;
        cfg_we   = we;
        cfg_ch   = ch;
        cfg_num  = n;
        cfg_den  = d;
        en = m_ready && lk;
        for (int i = 0; i < CH; i++) begin
            e_ck[i] = 1'b0;
            if (we && int'(ch) == i) begin
                m_num[i] = longint'(n);
                m_den[i] = longint'(d);
                m_k[i]   = 0;
            end else if (!en) begin
                m_k[i] = 0;
            end else if (m_num[i] != 0 && m_den[i] != 0) begin
                m_k[i]++;
                if (m_num[i] >= m_den[i]) e_ck[i] = 1'b1;
                else e_ck[i] = ((m_k[i] * m_num[i]) / m_den[i]) != (((m_k[i] - 1) * m_num[i]) / m_den[i]);
            end
        end
        m_streak = lk ? m_streak + 1 : 0;
        m_ready  = (m_streak >= LCK);
        sb_q.push_back({m_ready, e_ck});
        @(posedge clkin);
        #1;
        cfg_we = 1'b0;
        exp_v  = sb_q.pop_front();
        check("cycle_outputs", 64'({ready, clken}), 64'(exp_v));
        ck = clken;
        rd = ready;
    endtask

    task automatic run_lock(output int n);
        logic [CH-1:0] ck;
        logic          rd;
        n = 0;
        do begin
            step(1'b1, 1'b0, 2'd0, '0, '0, ck, rd);
            n++;
        end while (!rd && n < 100);
    endtask

    task automatic count_pulses(input int cycles, output int p0, output int p1, output int p2);
        logic [CH-1:0] ck;
        logic          rd;
        p0 = 0; p1 = 0; p2 = 0;
        for (int j = 0; j < cycles; j++) begin
            step(1'b1, 1'b0, 2'd0, '0, '0, ck, rd);
            p0 += int'(ck[0]);
            p1 += int'(ck[1]);
            p2 += int'(ck[2]);
        end
    endtask

    initial begin
        logic [CH-1:0] ck;
        logic          rd;
        int n, p0, p1, p2, consec, max_gap, last;

        reset = 1'b1; pll_lock = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_num = '0; cfg_den = '0;
        model_reset();
        #1;
        check("reset_ready", 64'(ready), 64'(0));
        check("reset_clken", 64'(clken), 64'(0));
        repeat (3) @(posedge clkin);
        @(negedge clkin);
        reset = 1'b0;
        repeat (4) step(1'b0, 1'b0, 2'd0, '0, '0, ck, rd);

        // Configure while not ready; channel 3 does not exist
        step(1'b0, 1'b1, 2'd0, 24'd3, 24'd7, ck, rd);
        step(1'b0, 1'b1, 2'd1, 24'd1, 24'd4, ck, rd);
        step(1'b0, 1'b1, 2'd3, 24'd1, 24'd1, ck, rd);

        run_lock(n);
        check("lock_latency", 64'(n), 64'(LCK));
        step(1'b0, 1'b0, 2'd0, '0, '0, ck, rd);
        check("lock_drop_ready", 64'(rd), 64'(0));
        check("lock_drop_clken", 64'(ck), 64'(0));

        n = 0;
        repeat (10) begin step(1'b1, 1'b0, 2'd0, '0, '0, ck, rd); n++; end
        step(1'b0, 1'b0, 2'd0, '0, '0, ck, rd); n++;
        do begin
            step(1'b1, 1'b0, 2'd0, '0, '0, ck, rd);
            n++;
        end while (!rd && n < 100);
        check("lock_glitch_latency", 64'(n), 64'(27));

        p0 = 0; p1 = 0; p2 = 0; consec = 0; max_gap = 0; last = -1;
        for (int j = 0; j < 7000; j++) begin
            step(1'b1, 1'b0, 2'd0, '0, '0, ck, rd);
            if (ck[0]) begin
                if (last >= 0 && j - last > max_gap) max_gap = j - last;
                if (last == j - 1) consec++;
                last = j;
                p0++;
            end
            p1 += int'(ck[1]);
            p2 += int'(ck[2]);
        end
        check("ratio_3_7_count", 64'(p0), 64'(3000));
        check("ratio_3_7_consecutive", 64'(consec), 64'(0));
        check("ratio_3_7_max_gap", 64'(max_gap), 64'(3));
        check("ratio_1_4_count", 64'(p1), 64'(1750));
        check("bad_channel_ignored", 64'(p2), 64'(0));

        step(1'b1, 1'b1, 2'd0, 24'd0, 24'd7, ck, rd);
        check("num0_write_clken", 64'(ck[0]), 64'(0));
        count_pulses(100, p0, p1, p2);
        check("num0_count", 64'(p0), 64'(0));
        step(1'b1, 1'b1, 2'd0, 24'd5, 24'd5, ck, rd);
        check("num_eq_den_write_clken", 64'(ck[0]), 64'(0));
        count_pulses(100, p0, p1, p2);
        check("num_eq_den_count", 64'(p0), 64'(100));
        step(1'b1, 1'b1, 2'd0, 24'd9, 24'd5, ck, rd);
        count_pulses(100, p0, p1, p2);
        check("num_gt_den_count", 64'(p0), 64'(100));
        step(1'b1, 1'b1, 2'd0, 24'd3, 24'd0, ck, rd);
        count_pulses(100, p0, p1, p2);
        check("den0_count", 64'(p0), 64'(0));

        step(1'b1, 1'b1, 2'd0, 24'd3, 24'd7, ck, rd);
        count_pulses(20, p0, p1, p2);
        step(1'b1, 1'b1, 2'd1, 24'd1, 24'd2, ck, rd);
        check("reconfig_n1_clken1", 64'(ck[1]), 64'(0));
        step(1'b1, 1'b0, 2'd0, '0, '0, ck, rd);
        step(1'b1, 1'b0, 2'd0, '0, '0, ck, rd);
        check("reconfig_first_pulse", 64'(ck[1]), 64'(1));
        count_pulses(20, p0, p1, p2);
        check("reconfig_1_2_count", 64'(p1), 64'(10));

        step(1'b0, 1'b0, 2'd0, '0, '0, ck, rd);
        check("loss_ready", 64'(rd), 64'(0));
        check("loss_clken", 64'(ck), 64'(0));
        run_lock(n);
        check("relock_latency", 64'(n), 64'(LCK));
        count_pulses(70, p0, p1, p2);
        check("retained_ch0", 64'(p0), 64'(30));
        check("retained_ch1", 64'(p1), 64'(35));

        @(negedge clkin);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_ready", 64'(ready), 64'(0));
        check("async_reset_clken", 64'(clken), 64'(0));
        model_reset();
        repeat (2) @(posedge clkin);
        @(negedge clkin);
        reset = 1'b0;
        repeat (4) step(1'b0, 1'b0, 2'd0, '0, '0, ck, rd);
        run_lock(n);
        check("post_reset_lock", 64'(n), 64'(LCK));
        count_pulses(20, p0, p1, p2);
        check("post_reset_num_cleared", 64'(p0 + p1), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
